wb_stage: RTL and testbench

- Parametrised, registered write-back stage: MEM/WB pipeline register, N-way result select, load-data alignment and extension, register-file write control.
- Sits between the data-memory stage and the register file.
- Also provides a bypass tap for the forwarding unit and a retired-instruction counter.
- Latency: 1 cycle from accepted input to register-file write.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_load_align.sv | 48 ++++
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source and load-size select fields.
package wb_pkg;

    typedef logic [1:0] src_sel_t;
    typedef logic [1:0] ld_size_t;

    localparam src_sel_t SRC_ALU  = 2'd0;
    localparam src_sel_t SRC_MEM  = 2'd1;
    localparam src_sel_t SRC_LINK = 2'd2;
    localparam src_sel_t SRC_IMM  = 2'd3;

    localparam ld_size_t LD_BYTE = 2'd0;
    localparam ld_size_t LD_HALF = 2'd1;
    localparam ld_size_t LD_WORD = 2'd2;
    localparam ld_size_t LD_RSVD = 2'd3;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian load lane selection with sign/zero extension and misalignment detection.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign
);

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] v, input logic uns);
        logic signed [7:0] sv;
        sv = v;
        return uns ? DATA_W'(v) : DATA_W'(sv);
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] v, input logic uns);
        logic signed [15:0] sv;
        sv = v;
        return uns ? DATA_W'(v) : DATA_W'(sv);
    endfunction

    logic [DATA_W-1:0] byte_shift;
    logic [DATA_W-1:0] half_shift;

    // Shifting instead of part-selecting keeps narrow DATA_W builds free of out-of-range lanes.
    assign byte_shift = mem_rdata >> {byte_off, 3'b000};
    assign half_shift = mem_rdata >> {byte_off[1], 4'b0000};

    always_comb begin
        ld_data  = mem_rdata;
        misalign = 1'b0;
        case (ld_size)
            LD_BYTE: ld_data = ext_byte(byte_shift[7:0], ld_unsigned);
            LD_HALF: begin
                ld_data  = ext_half(half_shift[15:0], ld_unsigned);
                misalign = byte_off[0];
            end
            LD_WORD: misalign = |byte_off;
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: result select, load alignment, register-file write control
// and a retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         src_sel,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic [DATA_W-1:0]  link_addr,
    input  logic [DATA_W-1:0]  imm_val,
    input  logic [1:0]         ld_size,
    input  logic               ld_unsigned,
    input  logic [1:0]         byte_off,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd_addr,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               out_valid,
    output logic               misalign,
    output logic [CNT_W-1:0]   retire_cnt
);

    logic [DATA_W-1:0]  ld_data;
    logic               lane_misalign;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               misalign_nxt;
    logic               we_nxt;

    logic               vld_p0;
    logic               rf_we_p0;
    logic               misalign_p0;
    logic [RADDR_W-1:0] rf_waddr_p0;
    logic [DATA_W-1:0]  rf_wdata_p0;
    logic [CNT_W-1:0]   retire_cnt_p0;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .mem_rdata   (mem_rdata),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .byte_off    (byte_off),
        .ld_data     (ld_data),
        .misalign    (lane_misalign)
    );

    always_comb begin
        wdata_nxt = alu_res;
        case (src_sel)
            SRC_ALU:  wdata_nxt = alu_res;
            SRC_MEM:  wdata_nxt = ld_data;
            SRC_LINK: wdata_nxt = link_addr;
            default:  wdata_nxt = imm_val;
        endcase
    end

    assign misalign_nxt = in_valid && (src_sel == SRC_MEM) && lane_misalign;
    assign we_nxt       = in_valid && reg_write && (rd_addr != '0) && !misalign_nxt;

    // Stage boundary: MEM -> WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0        <= 1'b0;
            rf_we_p0      <= 1'b0;
            misalign_p0   <= 1'b0;
            rf_waddr_p0   <= '0;
            rf_wdata_p0   <= '0;
            retire_cnt_p0 <= '0;
        end else begin
            if (vld_p0 && !stall && !flush)
                retire_cnt_p0 <= retire_cnt_p0 + CNT_W'(1);
            if (flush) begin
                vld_p0      <= 1'b0;
                rf_we_p0    <= 1'b0;
                misalign_p0 <= 1'b0;
            end else if (!stall) begin
                vld_p0      <= in_valid;
                rf_we_p0    <= we_nxt;
                misalign_p0 <= misalign_nxt;
                rf_waddr_p0 <= rd_addr;
                rf_wdata_p0 <= wdata_nxt;
            end
        end
    end

    assign out_valid  = vld_p0;
    assign rf_we      = rf_we_p0;
    assign misalign   = misalign_p0;
    assign rf_waddr   = rf_waddr_p0;
    assign rf_wdata   = rf_wdata_p0;
    assign retire_cnt = retire_cnt_p0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (CNT_W=4 so the retire counter wrap is reachable).
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  src_sel = 2'd0;
    logic [31:0] alu_res = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] link_addr = '0;
    logic [31:0] imm_val = '0;
    logic [1:0]  ld_size = 2'd0;
    logic        ld_unsigned = 1'b0;
    logic [1:0]  byte_off = 2'd0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_valid;
    logic        misalign;
    logic [3:0]  retire_cnt;

    int checks = 0;
    int failures = 0;

    wb_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_sel(src_sel), .alu_res(alu_res), .mem_rdata(mem_rdata), .link_addr(link_addr),
        .imm_val(imm_val), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
        .reg_write(reg_write), .rd_addr(rd_addr), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .out_valid(out_valid), .misalign(misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall = 0; flush = 0; src_sel = 0; alu_res = 0; mem_rdata = 0;
        link_addr = 0; imm_val = 0; ld_size = 0; ld_unsigned = 0; byte_off = 0;
        reg_write = 0; rd_addr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        in_valid = 1; reg_write = 1; alu_res = 32'hABCD; rd_addr = 5'd4;
        step();
        apply_reset();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
        repeat (5) step();
        checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL idle_retire got=%0d exp=0", retire_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_alu_write();
        apply_reset();
        in_valid = 1; reg_write = 1; src_sel = 2'd0; alu_res = 32'h0000_1234; rd_addr = 5'd7;
        step();
        idle_inputs();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_rf_we got=%b exp=1", rf_we); end
        checks++; if (rf_waddr !== 5'd7) begin failures++; $display("FAIL alu_rf_waddr got=%0d exp=7", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin failures++; $display("FAIL alu_rf_wdata got=%h exp=00001234", rf_wdata); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alu_out_valid got=%b exp=1", out_valid); end
        checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL alu_retire_early got=%0d exp=0", retire_cnt); end
        step();
        checks++; if (retire_cnt !== 4'd1) begin failures++; $display("FAIL alu_retire got=%0d exp=1", retire_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL alu_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_sources();
        apply_reset();
        in_valid = 1; reg_write = 1; rd_addr = 5'd12;
        alu_res = 32'h1111_1111; mem_rdata = 32'h2222_2222; link_addr = 32'h3333_3333; imm_val = 32'h4444_5000;
        src_sel = 2'd3;
        step();
        checks++; if (rf_wdata !== 32'h4444_5000) begin failures++; $display("FAIL src_imm got=%h exp=44445000", rf_wdata); end
        src_sel = 2'd2;
        step();
        checks++; if (rf_wdata !== 32'h3333_3333) begin failures++; $display("FAIL src_link got=%h exp=33333333", rf_wdata); end
        idle_inputs();
    endtask

    task automatic test_loads();
        logic [1:0]  sz  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [1:0]  off [8] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0};
        logic        uns [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp [8] = '{32'h0000_007F, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_0080,
                                 32'h0000_80FF, 32'h0000_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
        apply_reset();
        mem_rdata = 32'h80FF_7F01; src_sel = 2'd1; in_valid = 1; reg_write = 1; rd_addr = 5'd5;
        for (int i = 0; i < 8; i++) begin
            ld_size = sz[i]; byte_off = off[i]; ld_unsigned = uns[i];
            step();
            checks++; if (rf_wdata !== exp[i]) begin failures++; $display("FAIL load_data[%0d] got=%h exp=%h", i, rf_wdata, exp[i]); end
            checks++; if (rf_we !== 1'b1 || misalign !== 1'b0) begin failures++; $display("FAIL load_we[%0d] got we=%b mis=%b exp we=1 mis=0", i, rf_we, misalign); end
        end
        // Eight back-to-back loads leave the stage on edges 2..8 of the run.
        checks++; if (retire_cnt !== 4'd7) begin failures++; $display("FAIL load_retire got=%0d exp=7", retire_cnt); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        apply_reset();
        mem_rdata = 32'h80FF_7F01; in_valid = 1; reg_write = 1; rd_addr = 5'd9; src_sel = 2'd1;
        ld_size = 2'd1; byte_off = 2'd1;
        step();
        checks++; if (misalign !== 1'b1 || rf_we !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL mis_half got mis=%b we=%b vld=%b exp 1 0 1", misalign, rf_we, out_valid); end
        ld_size = 2'd2; byte_off = 2'd2;
        step();
        checks++; if (misalign !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL mis_word got mis=%b we=%b exp 1 0", misalign, rf_we); end
        ld_size = 2'd3; byte_off = 2'd0;
        step();
        checks++; if (misalign !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL mis_rsvd got mis=%b we=%b exp 1 0", misalign, rf_we); end
        src_sel = 2'd0; alu_res = 32'h0000_00AA; ld_size = 2'd2; byte_off = 2'd2;
        step();
        checks++; if (misalign !== 1'b0 || rf_we !== 1'b1) begin failures++; $display("FAIL mis_alu_src got mis=%b we=%b exp 0 1", misalign, rf_we); end
        src_sel = 2'd1; ld_size = 2'd1; byte_off = 2'd1; in_valid = 0;
        step();
        checks++; if (misalign !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mis_invalid got mis=%b vld=%b exp 0 0", misalign, out_valid); end
        in_valid = 1; src_sel = 2'd0; rd_addr = 5'd0; ld_size = 2'd2; byte_off = 2'd0;
        step();
        checks++; if (rf_we !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL r0_write got we=%b vld=%b exp 0 1", rf_we, out_valid); end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        apply_reset();
        in_valid = 1; reg_write = 1; src_sel = 2'd2; link_addr = 32'h0040_0008; rd_addr = 5'd31;
        step();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0040_0008) begin failures++; $display("FAIL link_load got we=%b addr=%0d data=%h exp 1 31 00400008", rf_we, rf_waddr, rf_wdata); end
        src_sel = 2'd0; alu_res = 32'hDEAD_BEEF; rd_addr = 5'd3; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rf_we !== 1'b1 || out_valid !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0040_0008) begin failures++; $display("FAIL stall_hold[%0d] got we=%b vld=%b addr=%0d data=%h", i, rf_we, out_valid, rf_waddr, rf_wdata); end
            checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL stall_retire[%0d] got=%0d exp=0", i, retire_cnt); end
        end
        flush = 1;
        step();
        checks++; if (out_valid !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL stall_flush got vld=%b we=%b exp 0 0", out_valid, rf_we); end
        checks++; if (rf_waddr !== 5'd31 || rf_wdata !== 32'h0040_0008) begin failures++; $display("FAIL flush_data_hold got addr=%0d data=%h exp 31 00400008", rf_waddr, rf_wdata); end
        checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL flush_retire got=%0d exp=0", retire_cnt); end
        stall = 0; flush = 0;
        step();
        stall = 1; reset = 1;
        step();
        reset = 0;
        checks++; if (out_valid !== 1'b0 || rf_we !== 1'b0 || rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_mid_stall got vld=%b we=%b addr=%0d data=%h", out_valid, rf_we, rf_waddr, rf_wdata); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        in_valid = 1; reg_write = 1; src_sel = 2'd0; alu_res = 32'h0000_0001; rd_addr = 5'd1;
        step();
        alu_res = 32'h0000_0002; rd_addr = 5'd2;
        checks++; if (rf_waddr !== 5'd1 || rf_wdata !== 32'h1) begin failures++; $display("FAIL b2b_first got addr=%0d data=%h exp 1 1", rf_waddr, rf_wdata); end
        step();
        idle_inputs();
        checks++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'h2 || retire_cnt !== 4'd1) begin failures++; $display("FAIL b2b_second got addr=%0d data=%h cnt=%0d exp 2 2 1", rf_waddr, rf_wdata, retire_cnt); end
        step();
        checks++; if (retire_cnt !== 4'd2) begin failures++; $display("FAIL b2b_retire got=%0d exp=2", retire_cnt); end
    endtask

    task automatic test_wrap();
        apply_reset();
        in_valid = 1; reg_write = 0; src_sel = 2'd0;
        repeat (17) step();
        in_valid = 0;
        step();
        checks++; if (retire_cnt !== 4'd1) begin failures++; $display("FAIL retire_wrap got=%0d exp=1", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_sources();
        test_loads();
        test_misalign();
        test_stall_flush();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
